pwm_duty_meter: RTL

- Receive-side counterpart of the LED glow PWM / first-order pulse-density generators.
- Samples a 1-bit PWM or pulse-density stream, measures its duty over fixed windows of 2^WIN_BITS clocks, and reports the recovered level, the rising-edge count and stuck flags.
- Used to loop back glow/PWM outputs for self-test and to monitor external 1-bit inputs for activity.

---
 rtl/pwm_duty_meter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_meter.sv
// -----------------------------------------------------------------------------
// pwm_duty_meter
// Measures the duty of a 1-bit PWM / pulse-density stream over fixed windows
// of 2^WIN_BITS clocks. This is the receive side of the glow/PWM generators and
// is used for loopback self-test and for activity monitoring of 1-bit inputs.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   enable     1 = measure, 0 = idle (outputs hold)
//   pwm_in     asynchronous 1-bit stream (double-flop synchronised)
//   duty_full  high-sample count of the last completed window, 0..2^WIN_BITS
//   duty       duty_full reduced to DUTY_BITS (top bits, all-ones when full)
//   edges      rising edges in the last window, saturating at 2^EDGE_W-1
//   valid      one-cycle strobe when the outputs update
//   stuck_hi   last window was all ones
//   stuck_lo   last window was all zeros
// -----------------------------------------------------------------------------
module pwm_duty_meter #(
   parameter int WIN_BITS  = 10,
   parameter int DUTY_BITS = 5,
   parameter int EDGE_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  pwm_in,
   output logic [WIN_BITS:0]     duty_full,
   output logic [DUTY_BITS-1:0]  duty,
   output logic [EDGE_W-1:0]     edges,
   output logic                  valid,
   output logic                  stuck_hi,
   output logic                  stuck_lo
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRIME   = 2'd1,
      MEASURE = 2'd2
   } state_t;

   state_t                state_reg, state_next;
   logic                  prime_cnt_reg;
   logic [1:0]            sync_reg;
   logic                  prev_reg;
   logic [WIN_BITS-1:0]   wcnt_reg;
   logic [WIN_BITS:0]     hcnt_reg;
   logic [EDGE_W-1:0]     ecnt_reg;

   logic [WIN_BITS:0]     duty_full_reg;
   logic [DUTY_BITS-1:0]  duty_reg;
   logic [EDGE_W-1:0]     edges_reg;
   logic                  valid_reg;
   logic                  stuck_hi_reg;
   logic                  stuck_lo_reg;

   // Synchronised sample: pwm_in as seen two edges earlier.
   logic                  s;
   logic                  rise;
   logic                  win_end;
   logic [WIN_BITS:0]     hcnt_next;
   logic [EDGE_W-1:0]     ecnt_next;
   logic [DUTY_BITS-1:0]  duty_next;

   assign s         = sync_reg[1];
   assign rise      = s & ~prev_reg;
   assign hcnt_next = hcnt_reg + (WIN_BITS+1)'(s);
   // Saturating edge count including the current sample.
   assign ecnt_next = (rise && (ecnt_reg != {EDGE_W{1'b1}})) ?
                      ecnt_reg + EDGE_W'(1) : ecnt_reg;
   assign win_end   = (state_reg == MEASURE) && enable &&
                      (wcnt_reg == {WIN_BITS{1'b1}});

   // Reduced duty: top DUTY_BITS of the count, forced to all-ones when the
   // count reaches 2^WIN_BITS (bit WIN_BITS set) since the slice would read 0.
   generate
      for (genvar gi = 0; gi < DUTY_BITS; gi++) begin : g_duty
         assign duty_next[gi] = hcnt_next[WIN_BITS] |
                                hcnt_next[WIN_BITS-DUTY_BITS+gi];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (enable) state_next = PRIME;
         PRIME: begin
            if (!enable)
               state_next = IDLE;
            else if (prime_cnt_reg)
               state_next = MEASURE;
         end
         MEASURE: if (!enable) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: synchroniser, window counters and registered results.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg      <= '0;
         prev_reg      <= 1'b0;
         prime_cnt_reg <= 1'b0;
         wcnt_reg      <= '0;
         hcnt_reg      <= '0;
         ecnt_reg      <= '0;
         duty_full_reg <= '0;
         duty_reg      <= '0;
         edges_reg     <= '0;
         valid_reg     <= 1'b0;
         stuck_hi_reg  <= 1'b0;
         stuck_lo_reg  <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[0], pwm_in};
         valid_reg <= 1'b0;
         case (state_reg)
            PRIME: begin
               wcnt_reg <= '0;
               hcnt_reg <= '0;
               ecnt_reg <= '0;
               if (enable && !prime_cnt_reg) begin
                  prime_cnt_reg <= 1'b1;
               end else begin
                  prime_cnt_reg <= 1'b0;
               end
               // Seed prev on the last priming clock so a stream that is
               // already high does not count as an edge.
               if (enable && prime_cnt_reg) begin
                  prev_reg <= s;
               end
            end
            MEASURE: begin
               prime_cnt_reg <= 1'b0;
               if (!enable) begin
                  wcnt_reg <= '0;
                  hcnt_reg <= '0;
                  ecnt_reg <= '0;
               end else begin
                  wcnt_reg <= wcnt_reg + WIN_BITS'(1);
                  prev_reg <= s;
                  if (win_end) begin
                     // Back-to-back windows: counters restart on the next clock.
                     hcnt_reg      <= '0;
                     ecnt_reg      <= '0;
                     duty_full_reg <= hcnt_next;
                     duty_reg      <= duty_next;
                     edges_reg     <= ecnt_next;
                     stuck_hi_reg  <= hcnt_next[WIN_BITS];
                     stuck_lo_reg  <= (hcnt_next == '0);
                     valid_reg     <= 1'b1;
                  end else begin
                     hcnt_reg <= hcnt_next;
                     ecnt_reg <= ecnt_next;
                  end
               end
            end
            default: begin
               prime_cnt_reg <= 1'b0;
               wcnt_reg      <= '0;
               hcnt_reg      <= '0;
               ecnt_reg      <= '0;
            end
         endcase
      end
   end

   assign duty_full = duty_full_reg;
   assign duty      = duty_reg;
   assign edges     = edges_reg;
   assign valid     = valid_reg;
   assign stuck_hi  = stuck_hi_reg;
   assign stuck_lo  = stuck_lo_reg;

endmodule
